data_mem_ctrl: RTL
==================

# data_mem_ctrl

Data-memory controller between the RV32I core's load/store port and a word-wide external data bus with a request/acknowledge handshake. It converts byte, halfword and word accesses into aligned word transactions with byte enables, and sign- or zero-extends load data. It stalls the core while a transaction is outstanding and flags misaligned accesses and bus timeouts.

## Interface
- TIMEOUT_CYCLES, 15: maximum REQ cycles without ack before the access is abandoned (valid range 1..255).
- clk_w_i  in  1  clock; all state updates on rising edge.
- res_w_i_h  in  1  reset; synchronous and active-high.
- cpu_addr_w_i  in  32  byte address (core ALU result).
- cpu_wdata_w_i  in  32  store data (core rs2).
- cpu_rd_w_i_h  in  1  load request, level.
- cpu_wr_w_i_h  in  1  store request, level; wins if both are set.
- cpu_funct3_w_i  in  3  access size/sign (RV32I funct3).
- cpu_rdata_w_o  out  32  extended load data.
- stall_w_o_h  out  1  core must hold its PC and instruction.
- misalign_w_o_h  out  1  misaligned or illegal-size access.
- bus_err_w_o_h  out  1  bus timeout on the completed access.
- bus_addr_w_o  out  32  word address, {addr[31:2],2'b00}.
- bus_wdata_w_o  out  32  lane-replicated store data.
- bus_be_w_o  out  4  byte enables.
- bus_we_w_o_h  out  1  write strobe.
- bus_req_w_o_h  out  1  transaction request.
- bus_ack_w_i_h  in  1  transaction complete.
- bus_rdata_w_i  in  32  read word, valid with ack.

## Operation
- States: IDLE, REQ, DONE.
- Access = cpu_rd | cpu_wr. Legal sizes: loads funct3 0,1,2,4,5; stores 0,1,2. Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
- IDLE, access, illegal size or misaligned: misalign_w_o_h=1 (combinational), stall=0, no bus activity, state stays IDLE.
- IDLE, access, legal: stall=1 (combinational). Latch addr, we, be, wdata, funct3, addr[1:0]. Go to REQ.
- Byte enables: byte → 4'b0001<<addr[1:0]; half → 4'b0011<<{addr[1],1'b0}; word → 4'b1111. Loads drive the same be.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
- REQ: bus_req=1. Addr, wdata, be and we are held stable. stall=1. Count cycles.
  - Ack sampled high: capture extended read data; go to DONE with bus_err=0.
  - TIMEOUT_CYCLES REQ cycles elapse without ack: rdata=0, bus_err=1; go to DONE. Ack on the final REQ cycle counts as success.
- Load extraction: lane = bus_rdata>>(8*addr[1:0]). LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word. Stores leave rdata=0.
- DONE: stall=0, cpu_rdata and bus_err valid, bus_req=0. Unconditionally return to IDLE next cycle. A request still present in IDLE starts a new access.
- bus_ack while bus_req=0 is ignored.

## Timing
- Reset values: state IDLE; bus_req, bus_we=0; bus_be=0; bus_addr, bus_wdata=0; cpu_rdata=0; bus_err=0; counter=0. stall and misalign are 0 when no access is present.
- bus_* outputs are registered. stall_w_o_h and misalign_w_o_h are combinational from state and core inputs.
- Minimum access latency: request seen in cycle 0 (IDLE); bus_req is high in cycle 1; ack in cycle 1 gives DONE in cycle 2. Stall is high for N+2 cycles, where N is the number of wait cycles before ack.
- bus_req drops in the cycle after ack or timeout. There are no back-to-back requests; at least one DONE cycle separates them.
- Reset mid-access: the next edge forces IDLE. bus_req is low in the following cycle and the pending result is discarded.

## Test plan
- LB then LBU at 0x1003, bus_rdata 0x80FF1234, ack in cycle 1 → bus_addr 0x1000, be 4'b1000; rdata 0xFFFFFF80 then 0x00000080; stall exactly 2 cycles each.
- SH 0x2002, wdata 0x0000BEEF → bus_addr 0x2000, be 4'b1100, bus_wdata 0xBEEFBEEF, we=1; rdata 0.
- LW 0x3001, and LH 0x3005 → misalign=1 same cycle, stall=0, bus_req never asserted.
- LW 0x4000, ack after 3 wait cycles with 0xDEADBEEF → req high 4 cycles, stall high 5 cycles, rdata 0xDEADBEEF in DONE.
- LW 0x5000 with no ack, TIMEOUT_CYCLES=15 → req high 15 cycles, DONE with bus_err=1, rdata 0; a late ack is ignored.
- Reset asserted on the 2nd REQ cycle → bus_req=0 and all outputs at reset values the next cycle; a new LW then completes normally.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: turns RV32I byte/half/word loads and stores into aligned
// word bus transactions with byte enables, stalls the core and extends load data.
module data_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk_w_i,
  input  logic        res_w_i_h,
  input  logic [31:0] cpu_addr_w_i,
  input  logic [31:0] cpu_wdata_w_i,
  input  logic        cpu_rd_w_i_h,
  input  logic        cpu_wr_w_i_h,
  input  logic [2:0]  cpu_funct3_w_i,
  output logic [31:0] cpu_rdata_w_o,
  output logic        stall_w_o_h,
  output logic        misalign_w_o_h,
  output logic        bus_err_w_o_h,
  output logic [31:0] bus_addr_w_o,
  output logic [31:0] bus_wdata_w_o,
  output logic [3:0]  bus_be_w_o,
  output logic        bus_we_w_o_h,
  output logic        bus_req_w_o_h,
  input  logic        bus_ack_w_i_h,
  input  logic [31:0] bus_rdata_w_i
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_nxt;
  logic        access, size_legal, aligned, start, timeout;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] lane, ext;

  always_comb begin
    access     = cpu_rd_w_i_h | cpu_wr_w_i_h;
    size_legal = 1'b0;
    aligned    = 1'b1;
    be_nxt     = 4'b1111;
    wdata_nxt  = cpu_wdata_w_i;
    // Store wins when both requests are set, so it selects the legal size set.
    if (cpu_wr_w_i_h)
      size_legal = cpu_funct3_w_i inside {3'd0, 3'd1, 3'd2};
    else
      size_legal = cpu_funct3_w_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    case (cpu_funct3_w_i[1:0])
      2'd0: begin
        be_nxt    = 4'b0001 << cpu_addr_w_i[1:0];
        wdata_nxt = {4{cpu_wdata_w_i[7:0]}};
      end
      2'd1: begin
        aligned   = ~cpu_addr_w_i[0];
        be_nxt    = 4'b0011 << {cpu_addr_w_i[1], 1'b0};
        wdata_nxt = {2{cpu_wdata_w_i[15:0]}};
      end
      2'd2: aligned = (cpu_addr_w_i[1:0] == 2'b00);
      default: ;
    endcase
    start   = access && size_legal && aligned;
    timeout = (cnt == 8'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    lane = bus_rdata_w_i >> {off_q, 3'b000};
    case (f3_q)
      3'd0:    ext = {{24{lane[7]}}, lane[7:0]};
      3'd1:    ext = {{16{lane[15]}}, lane[15:0]};
      3'd4:    ext = {24'h0, lane[7:0]};
      3'd5:    ext = {16'h0, lane[15:0]};
      default: ext = lane;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    stall_w_o_h    = 1'b0;
    misalign_w_o_h = 1'b0;
    case (state)
      IDLE: begin
        misalign_w_o_h = access && !start;
        stall_w_o_h    = start;
        if (start) state_nxt = REQ;
      end
      REQ: begin
        stall_w_o_h = 1'b1;
        if (bus_ack_w_i_h || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_w_i) begin
    if (res_w_i_h) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge clk_w_i) begin
    if (res_w_i_h) begin
      bus_addr_w_o  <= '0;
      bus_wdata_w_o <= '0;
      bus_be_w_o    <= '0;
      bus_we_w_o_h  <= 1'b0;
      bus_req_w_o_h <= 1'b0;
      cpu_rdata_w_o <= '0;
      bus_err_w_o_h <= 1'b0;
      cnt           <= '0;
      f3_q          <= '0;
      off_q         <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bus_addr_w_o  <= {cpu_addr_w_i[31:2], 2'b00};
          bus_wdata_w_o <= wdata_nxt;
          bus_be_w_o    <= be_nxt;
          bus_we_w_o_h  <= cpu_wr_w_i_h;
          bus_req_w_o_h <= 1'b1;
          f3_q          <= cpu_funct3_w_i;
          off_q         <= cpu_addr_w_i[1:0];
          cnt           <= '0;
          cpu_rdata_w_o <= '0;
          bus_err_w_o_h <= 1'b0;
        end
        REQ: begin
          // An ack on the final REQ cycle takes priority over the timeout.
          if (bus_ack_w_i_h) begin
            bus_req_w_o_h <= 1'b0;
            bus_we_w_o_h  <= 1'b0;
            cpu_rdata_w_o <= bus_we_w_o_h ? '0 : ext;
            bus_err_w_o_h <= 1'b0;
          end else if (timeout) begin
            bus_req_w_o_h <= 1'b0;
            bus_we_w_o_h  <= 1'b0;
            cpu_rdata_w_o <= '0;
            bus_err_w_o_h <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
